// File: rtl/sram_byte_streamer_pkg.sv
// Shared constants and FSM encoding for the SRAM-to-byte-stream reader.
package sram_byte_streamer_pkg;
  localparam int ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF     = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BIDX_W         = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOAD = 2'd2,
    ST_SEND = 2'd3
  } state_t;
endpackage

// File: rtl/sram_byte_streamer_if.sv
// Byte-stream handshake between the streamer and its downstream consumer.
interface sram_byte_streamer_if;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  modport master (output m_valid, m_data, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/sram_byte_streamer_byte_serializer.sv
// Holds one SRAM word and hands it out MSB byte first under valid/ready.
module byte_serializer
  import sram_byte_streamer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_word,
  input  logic              load_last,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [7:0]        m_data,
  output logic              m_last,
  output logic              word_done
);
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] shifted;
  logic [BIDX_W-1:0] idx_q;
  logic              vld_q;
  logic              last_q;
  logic              fire;

  assign fire      = vld_q && m_ready;
  assign word_done = fire && (idx_q == BIDX_W'(BYTES_PER_WORD - 1));

  // Shifting the word left by 8*idx brings the current byte to the top.
  assign shifted = word_q << {idx_q, 3'b000};
  assign m_data  = shifted[DATA_W-1 -: 8];
  assign m_valid = vld_q;
  assign m_last  = vld_q && last_q && (idx_q == BIDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else if (load) begin
      word_q <= load_word;
      idx_q  <= '0;
      vld_q  <= 1'b1;
      last_q <= load_last;
    end else if (fire) begin
      idx_q <= idx_q + 1'b1;
      if (word_done) vld_q <= 1'b0;
    end
  end
endmodule

// File: rtl/sram_byte_streamer.sv
// Reads a burst of words from a 1-cycle-latency SRAM and streams them out bytewise.
module sram_byte_streamer
  import sram_byte_streamer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              busy,
  output logic              done,
  output logic              sram_csb,
  output logic              sram_wsb,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata,
  sram_byte_streamer_if.master m
);
  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] left_q;
  logic              word_done;

  assign sram_wsb   = 1'b1;
  assign sram_raddr = addr_q;

  // left_q counts the word currently in flight, so 1 means this is the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sram_csb <= 1'b1;
      addr_q   <= '0;
      left_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              addr_q   <= base_addr;
              left_q   <= num_words;
              busy     <= 1'b1;
              sram_csb <= 1'b0;
              state    <= ST_REQ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          sram_csb <= 1'b1;
          state    <= ST_LOAD;
        end
        ST_LOAD: state <= ST_SEND;
        ST_SEND: begin
          if (word_done) begin
            if (left_q == ADDR_W'(1)) begin
              left_q <= '0;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              addr_q   <= addr_q + 1'b1;
              left_q   <= left_q - 1'b1;
              sram_csb <= 1'b0;
              state    <= ST_REQ;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  byte_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state == ST_LOAD),
    .load_word (sram_rdata),
    .load_last (left_q == ADDR_W'(1)),
    .m_ready   (m.m_ready),
    .m_valid   (m.m_valid),
    .m_data    (m.m_data),
    .m_last    (m.m_last),
    .word_done (word_done)
  );
endmodule

// File: tb/tb_sram_byte_streamer.sv
// Directed bench: SRAM model, passive monitor, one task per scenario.
module tb_sram_byte_streamer;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_words = '0;
  logic          busy, done, sram_csb, sram_wsb;
  logic [AW-1:0] sram_raddr;
  logic [DW-1:0] sram_rdata;

  sram_byte_streamer_if sif ();

  sram_byte_streamer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .busy       (busy),
    .done       (done),
    .sram_csb   (sram_csb),
    .sram_wsb   (sram_wsb),
    .sram_raddr (sram_raddr),
    .sram_rdata (sram_rdata),
    .m          (sif)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  always @(posedge clk) if (!sram_csb) sram_rdata <= mem[sram_raddr];

  int checks = 0;
  int fails  = 0;

  // Monitor: samples at posedge, before the DUT's nonblocking updates land.
  logic [7:0] byte_q [$];
  bit         last_q [$];
  int         byte_cyc [$];
  int         addr_q [$];
  int         csb_cyc [$];
  int         cyc = 0, done_cnt = 0, done_cyc = 0, stall_err = 0, stall_cnt = 0, vld_cnt = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  always @(posedge clk) begin
    if (rst_n) begin
      cyc++;
      if (!sram_csb) begin addr_q.push_back(int'(sram_raddr)); csb_cyc.push_back(cyc); end
      if (sif.m_valid && sif.m_ready) begin
        byte_q.push_back(sif.m_data); last_q.push_back(sif.m_last); byte_cyc.push_back(cyc);
      end
      if (sif.m_valid) vld_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (prev_stall && (!sif.m_valid || sif.m_data !== prev_data || sif.m_last !== prev_last))
        stall_err++;
      if (sif.m_valid && !sif.m_ready) stall_cnt++;
      prev_stall = sif.m_valid && !sif.m_ready;
      prev_data  = sif.m_data;
      prev_last  = sif.m_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  bit poke_busy = 1'b0;

  // Launch a burst and wait for done; stall applies a 1-0-0-1 m_ready pattern.
  task automatic run_burst(input logic [AW-1:0] base, input logic [AW-1:0] num,
                           input bit stall, input int poke_at, output bit timeout);
    logic [3:0] pat = 4'b1001;
    int d0 = done_cnt;
    @(negedge clk); start = 1'b1; base_addr = base; num_words = num;
    @(negedge clk); start = 1'b0;
    timeout = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      sif.m_ready = stall ? pat[i % 4] : 1'b1;
      start = 1'b0;
      if (i == poke_at) begin
        poke_busy = busy; start = 1'b1; base_addr = 10'd100; num_words = 10'd7;
      end
      if (done_cnt != d0) begin timeout = 1'b0; break; end
    end
    start = 1'b0; sif.m_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (sif.m_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", sif.m_valid); end
    checks++; if (sif.m_last !== 1'b0) begin fails++; $display("FAIL reset_last got %b want 0", sif.m_last); end
    checks++; if (sif.m_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", sif.m_data); end
    checks++; if (sram_csb !== 1'b1) begin fails++; $display("FAIL reset_csb got %b want 1", sram_csb); end
    checks++; if (sram_wsb !== 1'b1) begin fails++; $display("FAIL reset_wsb got %b want 1", sram_wsb); end
    checks++; if (sram_raddr !== 10'd0) begin fails++; $display("FAIL reset_raddr got %0d want 0", sram_raddr); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || sram_csb !== 1'b1) begin fails++; $display("FAIL idle_after_reset busy=%b csb=%b want 0/1", busy, sram_csb); end
  endtask

  task automatic test_basic();
    logic [7:0] exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    int b0 = byte_q.size(), a0 = addr_q.size(), d0 = done_cnt;
    bit to;
    mem[5] = 32'h11223344; mem[6] = 32'h55667788;
    run_burst(10'd5, 10'd2, 1'b0, -1, to);
    checks++; if (to) begin fails++; $display("FAIL basic_timeout got timeout want done"); end
    checks++; if (byte_q.size() - b0 != 8) begin fails++; $display("FAIL basic_count got %0d want 8", byte_q.size() - b0); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (byte_q[b0+i] !== exp[i]) begin fails++; $display("FAIL basic_byte%0d got %h want %h", i, byte_q[b0+i], exp[i]); end
        checks++; if (last_q[b0+i] !== (i == 7)) begin fails++; $display("FAIL basic_last%0d got %b want %b", i, last_q[b0+i], i == 7); end
      end
      checks++; if (done_cyc - byte_cyc[b0+7] != 1) begin fails++; $display("FAIL basic_done_lag got %0d want 1", done_cyc - byte_cyc[b0+7]); end
    end
    checks++; if (addr_q.size() - a0 != 2) begin fails++; $display("FAIL basic_csb_count got %0d want 2", addr_q.size() - a0); end
    else begin
      checks++; if (addr_q[a0] != 5 || addr_q[a0+1] != 6) begin fails++; $display("FAIL basic_addr got %0d,%0d want 5,6", addr_q[a0], addr_q[a0+1]); end
      checks++; if (byte_cyc[b0] - csb_cyc[a0] != 2) begin fails++; $display("FAIL basic_latency got %0d want 2", byte_cyc[b0] - csb_cyc[a0]); end
      checks++; if (csb_cyc[a0+1] - csb_cyc[a0] != 6) begin fails++; $display("FAIL basic_word_period got %0d want 6", csb_cyc[a0+1] - csb_cyc[a0]); end
    end
    checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL basic_done_count got %0d want 1", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_end got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    int b0 = byte_q.size(), a0 = addr_q.size();
    bit to;
    mem[1023] = 32'hA0A1A2A3; mem[0] = 32'hB0B1B2B3;
    run_burst(10'd1023, 10'd2, 1'b0, -1, to);
    checks++; if (to) begin fails++; $display("FAIL wrap_timeout got timeout want done"); end
    checks++; if (addr_q.size() - a0 != 2) begin fails++; $display("FAIL wrap_csb_count got %0d want 2", addr_q.size() - a0); end
    else begin
      checks++; if (addr_q[a0] != 1023 || addr_q[a0+1] != 0) begin fails++; $display("FAIL wrap_addr got %0d,%0d want 1023,0", addr_q[a0], addr_q[a0+1]); end
    end
    checks++; if (byte_q.size() - b0 != 8) begin fails++; $display("FAIL wrap_count got %0d want 8", byte_q.size() - b0); end
    else for (int i = 0; i < 8; i++) begin
      checks++; if (byte_q[b0+i] !== exp[i]) begin fails++; $display("FAIL wrap_byte%0d got %h want %h", i, byte_q[b0+i], exp[i]); end
    end
  endtask

  task automatic test_zero_len();
    int a0 = addr_q.size(), v0 = vld_cnt, d0 = done_cnt;
    @(negedge clk); start = 1'b1; base_addr = 10'd9; num_words = 10'd0;
    @(negedge clk); start = 1'b0;
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL zero_done got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy got %b want 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL zero_done_pulse got %b want 0", done); end
    repeat (3) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL zero_done_count got %0d want 1", done_cnt - d0); end
    checks++; if (addr_q.size() != a0) begin fails++; $display("FAIL zero_csb got %0d reads want 0", addr_q.size() - a0); end
    checks++; if (vld_cnt != v0) begin fails++; $display("FAIL zero_valid got %0d want 0", vld_cnt - v0); end
  endtask

  task automatic test_stall();
    logic [7:0] exp [12] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0B, 8'hAD, 8'hF0, 8'h0D,
                              8'hCA, 8'hFE, 8'hBA, 8'hBE};
    int b0 = byte_q.size(), s0 = stall_err, c0 = stall_cnt;
    bit to;
    mem[20] = 32'hDEADBEEF; mem[21] = 32'h0BADF00D; mem[22] = 32'hCAFEBABE;
    run_burst(10'd20, 10'd3, 1'b1, -1, to);
    checks++; if (to) begin fails++; $display("FAIL stall_timeout got timeout want done"); end
    checks++; if (stall_err != s0) begin fails++; $display("FAIL stall_stable got %0d changes want 0", stall_err - s0); end
    checks++; if (stall_cnt == c0) begin fails++; $display("FAIL stall_occurred got 0 stall cycles want >0"); end
    checks++; if (byte_q.size() - b0 != 12) begin fails++; $display("FAIL stall_count got %0d want 12", byte_q.size() - b0); end
    else for (int i = 0; i < 12; i++) begin
      checks++; if (byte_q[b0+i] !== exp[i] || last_q[b0+i] !== (i == 11)) begin
        fails++; $display("FAIL stall_byte%0d got %h/%b want %h/%b", i, byte_q[b0+i], last_q[b0+i], exp[i], i == 11);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [7:0] exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    int b0 = byte_q.size(), a0 = addr_q.size(), d0 = done_cnt;
    bit to;
    mem[100] = 32'hFFFFFFFF;
    run_burst(10'd5, 10'd2, 1'b0, 3, to);
    checks++; if (to) begin fails++; $display("FAIL ign_timeout got timeout want done"); end
    checks++; if (poke_busy !== 1'b1) begin fails++; $display("FAIL ign_busy got %b want 1", poke_busy); end
    checks++; if (addr_q.size() - a0 != 2) begin fails++; $display("FAIL ign_csb_count got %0d want 2", addr_q.size() - a0); end
    else begin
      checks++; if (addr_q[a0] != 5 || addr_q[a0+1] != 6) begin fails++; $display("FAIL ign_addr got %0d,%0d want 5,6", addr_q[a0], addr_q[a0+1]); end
    end
    checks++; if (byte_q.size() - b0 != 8) begin fails++; $display("FAIL ign_count got %0d want 8", byte_q.size() - b0); end
    else for (int i = 0; i < 8; i++) begin
      checks++; if (byte_q[b0+i] !== exp[i]) begin fails++; $display("FAIL ign_byte%0d got %h want %h", i, byte_q[b0+i], exp[i]); end
    end
    repeat (4) @(negedge clk);
    checks++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin fails++; $display("FAIL ign_done got %0d busy=%b want 1/0", done_cnt - d0, busy); end
  endtask

  task automatic test_reset_mid();
    int b0 = byte_q.size(), d0;
    bit reached = 1'b0, to;
    mem[30] = 32'h01020304; mem[31] = 32'h05060708; mem[32] = 32'h090A0B0C;
    @(negedge clk); start = 1'b1; base_addr = 10'd30; num_words = 10'd3;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (byte_q.size() - b0 >= 5) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin fails++; $display("FAIL rmid_reach got timeout want 5 bytes"); end
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    checks++; if (sif.m_valid !== 1'b0 || sif.m_last !== 1'b0 || sif.m_data !== 8'h00) begin
      fails++; $display("FAIL rmid_stream got v=%b l=%b d=%h want 0/0/00", sif.m_valid, sif.m_last, sif.m_data);
    end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rmid_ctl got busy=%b done=%b want 0/0", busy, done); end
    checks++; if (sram_csb !== 1'b1 || sram_raddr !== 10'd0) begin fails++; $display("FAIL rmid_sram got csb=%b addr=%0d want 1/0", sram_csb, sram_raddr); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (done_cnt != d0) begin fails++; $display("FAIL rmid_no_done got %0d pulses want 0", done_cnt - d0); end
    b0 = byte_q.size();
    run_burst(10'd30, 10'd3, 1'b0, -1, to);
    checks++; if (to) begin fails++; $display("FAIL rmid_rerun_timeout got timeout want done"); end
    checks++; if (byte_q.size() - b0 != 12) begin fails++; $display("FAIL rmid_count got %0d want 12", byte_q.size() - b0); end
    else for (int i = 0; i < 12; i++) begin
      checks++; if (byte_q[b0+i] !== 8'(i + 1) || last_q[b0+i] !== (i == 11)) begin
        fails++; $display("FAIL rmid_byte%0d got %h/%b want %h/%b", i, byte_q[b0+i], last_q[b0+i], 8'(i + 1), i == 11);
      end
    end
  endtask

  initial begin
    sif.m_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_stall();
    test_ignore_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/sram_byte_streamer.md
SRAM_BYTE_STREAMER -- requirements
Module: sram_byte_streamer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning SRAM word width (fixed at 4 bytes).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_W  first word address, captured on accepted start.
REQ-007 SHALL have port num_words  input  ADDR_W  burst length in words, captured on accepted start.
REQ-008 SHALL have port busy  output  1  high from accepted start until the done pulse.
REQ-009 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-010 SHALL have port sram_csb  output  1  SRAM chip enable, active-low.
REQ-011 SHALL have port sram_wsb  output  1  SRAM write enable, active-low; constant 1.
REQ-012 SHALL have port sram_raddr  output  ADDR_W  SRAM read address.
REQ-013 SHALL have port sram_rdata  input  DATA_W  SRAM read data, valid the cycle after csb low.
REQ-014 SHALL have port m_valid  output  1  output byte valid.
REQ-015 SHALL have port m_ready  input  1  downstream accepts byte.
REQ-016 SHALL have port m_data  output  8  output byte.
REQ-017 SHALL have port m_last  output  1  marks final byte of burst.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, LOAD, SEND.
REQ-019 IDLE: start=1 and num_words!=0 SHALL capture base_addr/num_words and enter REQ; start=1 and num_words=0 SHALL pulse done next cycle and remain IDLE.
REQ-020 REQ: sram_csb=0, sram_raddr=current address for exactly one cycle; next state LOAD.
REQ-021 LOAD: sram_csb=1; word register SHALL capture sram_rdata; next state SEND.
REQ-022 SEND SHALL present bytes in order [31:24], [23:16], [15:8], [7:0]; byte index advances only on m_valid&&m_ready.
REQ-023 m_valid SHALL be high only in SEND; m_data/m_last SHALL stay stable while m_valid&&!m_ready.
REQ-024 After byte [7:0] handshake: if words remain, address increments by 1 mod 2^ADDR_W (wraps 1023->0) and next state REQ; else next state IDLE with done=1 for that cycle.
REQ-025 m_last SHALL be 1 only on byte [7:0] of the last word.
REQ-026 start asserted while busy SHALL be ignored; base_addr/num_words changes mid-burst SHALL have no effect.
REQ-027 sram_csb SHALL be 1 in every state except REQ; write path never asserted.
REQ-028 Word issue-to-first-byte latency SHALL be 2 cycles; zero-stall throughput 6 cycles/word.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, busy=0, done=0, m_valid=0, m_last=0, m_data=0, sram_csb=1, sram_raddr=0, counters and word register to 0.
REQ-030 Reset mid-burst SHALL abandon the burst without done pulse; first start after release SHALL run normally.

Structure
REQ-031 FSM state encoding, ADDR_W/DATA_W defaults and byte-count constant (4) SHALL live in a shared package.
REQ-032 Byte serialization (word register, byte index, valid/last) SHALL be sub-module byte_serializer; FSM and address/word counters in top.

Verification
REQ-033 SRAM preload 0x11223344 at 5, 0x55667788 at 6; start base=5 num=2, m_ready=1 -> bytes 11,22,33,44,55,66,77,88, m_last only on 88, done one cycle later, csb low exactly twice.
REQ-034 base=1023 num=2 -> reads addresses 1023 then 0 in order.
REQ-035 num=0 -> done pulse next cycle, csb never low, m_valid never high.
REQ-036 m_ready toggled 1-0-0-1 pseudo-randomly -> m_data/m_last stable during stalls, no byte lost or duplicated.
REQ-037 start pulsed during burst with different base -> ignored, original sequence unchanged.
REQ-038 rst_n low during SEND of word 1 of 3 -> outputs at reset values immediately, no done; fresh burst after release correct.
